// File: rtl/alu_sequencer.sv
// Iterative ALU sequencer: repeatedly applies one op to an accumulator using an external ALU.
// Optional ALU_SEQUENCER_EARLY_STOP_EN ends the sequence on the first zero result.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_count,
  output logic [3:0] alu_src_a,
  output logic [3:0] alu_src_b,
  output logic [2:0] alu_operation,
  input  logic [3:0] alu_result,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_zero,
  output logic [3:0] rsp_iters,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // cmd_ready depends only on state, and rsp_* hold steady while rsp_valid waits for rsp_ready.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [2:0] rem_q, rem_d;
  logic [3:0] iters_q, iters_d;
  logic       zero_q, zero_d;
  logic       last_iter;

`ifdef ALU_SEQUENCER_EARLY_STOP_EN
  assign last_iter = (rem_q == 3'd0) || alu_zero;
`else
  assign last_iter = (rem_q == 3'd0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      iters_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      iters_q <= iters_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    b_d           = b_q;
    op_d          = op_q;
    rem_d         = rem_q;
    iters_d       = iters_q;
    zero_d        = zero_q;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_result    = '0;
    rsp_zero      = 1'b0;
    rsp_iters     = '0;
    alu_src_a     = '0;
    alu_src_b     = '0;
    alu_operation = '0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          acc_d   = cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          rem_d   = cmd_count;
          iters_d = '0;
          zero_d  = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_src_a     = acc_q;
        alu_src_b     = b_q;
        alu_operation = op_q;
        acc_d         = alu_result;
        zero_d        = alu_zero;
        iters_d       = iters_q + 4'd1;
        if (last_iter) state_d = S_DONE;
        else           rem_d   = rem_q - 3'd1;
      end
      S_DONE: begin
        rsp_valid  = 1'b1;
        rsp_result = acc_q;
        rsp_zero   = zero_q;
        rsp_iters  = iters_q;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU closing the loop.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [2:0] cmd_count;
  logic [3:0] alu_src_a, alu_src_b;
  logic [2:0] alu_operation;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_zero;
  logic [3:0] rsp_iters;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_b;
  logic [2:0] exp_op;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_DONE = 2'd2;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_count(cmd_count),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_iters(rsp_iters), .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  // reference ALU: 0 AND, 1 OR, 2 ADD, 3 SHL by one, 4 SUB, else XOR
  always_comb begin
    case (alu_operation)
      3'd0:    alu_result = alu_src_a & alu_src_b;
      3'd1:    alu_result = alu_src_a | alu_src_b;
      3'd2:    alu_result = alu_src_a + alu_src_b;
      3'd3:    alu_result = alu_src_a << 1;
      3'd4:    alu_result = alu_src_a - alu_src_b;
      default: alu_result = alu_src_a ^ alu_src_b;
    endcase
    alu_zero = (alu_result == 4'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_count = cnt;
    exp_b     = b;
    exp_op    = op;
    step();
    cmd_valid = 1'b0;
    cmd_op    = $urandom_range(0, 7);
    cmd_a     = $urandom_range(0, 15);
    cmd_b     = $urandom_range(0, 15);
    cmd_count = $urandom_range(0, 7);
  endtask

  // scoreboard: one expected accumulator per ISSUE cycle
  task automatic run_issue();
    logic [3:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (dbg_state !== ST_ISSUE || alu_src_a !== e || alu_src_b !== exp_b ||
          alu_operation !== exp_op || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL issue: state=%0d a=%0d b=%0d op=%0d rv=%0b cr=%0b required state=1 a=%0d b=%0d op=%0d rv=0 cr=0",
                 dbg_state, alu_src_a, alu_src_b, alu_operation, rsp_valid, cmd_ready, e, exp_b, exp_op);
      end
      step();
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_count = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || dbg_state !== ST_IDLE ||
        alu_src_a !== 4'd0 || alu_src_b !== 4'd0 || alu_operation !== 3'd0 ||
        rsp_result !== 4'd0 || rsp_zero !== 1'b0 || rsp_iters !== 4'd0) begin
      bad++;
      $display("FAIL reset: cr=%0b rv=%0b st=%0d a=%0d b=%0d op=%0d res=%0d z=%0b it=%0d required cr=1 all else 0",
               cmd_ready, rsp_valid, dbg_state, alu_src_a, alu_src_b, alu_operation, rsp_result, rsp_zero, rsp_iters);
    end
  endtask

  task automatic check_done(input string name, input logic [3:0] r, input logic z, input logic [3:0] it);
    total++;
    if (rsp_valid !== 1'b1 || dbg_state !== ST_DONE || rsp_result !== r || rsp_zero !== z ||
        rsp_iters !== it || cmd_ready !== 1'b0 || alu_src_a !== 4'd0 || alu_operation !== 3'd0) begin
      bad++;
      $display("FAIL %s: rv=%0b res=%0d z=%0b it=%0d cr=%0b alu_a=%0d required rv=1 res=%0d z=%0b it=%0d cr=0 alu_a=0",
               name, rsp_valid, rsp_result, rsp_zero, rsp_iters, cmd_ready, alu_src_a, r, z, it);
    end
  endtask

  task automatic check_idle(input string name);
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_result !== 4'd0 ||
        rsp_iters !== 4'd0 || rsp_zero !== 1'b0 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL %s: rv=%0b cr=%0b res=%0d it=%0d z=%0b st=%0d required rv=0 cr=1 rsp=0 st=0",
               name, rsp_valid, cmd_ready, rsp_result, rsp_iters, rsp_zero, dbg_state);
    end
  endtask

  task automatic test_add();
    exp_q = '{4'd3, 4'd8, 4'd13};
    send_cmd(3'd2, 4'd3, 4'd5, 3'd2);
    run_issue();
    check_done("add_result_cycle4", 4'd2, 1'b0, 4'd3);
    handshake();
    check_idle("add_after_handshake");
  endtask

  task automatic test_sub();
`ifdef ALU_SEQUENCER_EARLY_STOP_EN
    exp_q = '{4'd6, 4'd4, 4'd2};
    send_cmd(3'd4, 4'd6, 4'd2, 3'd7);
    run_issue();
    check_done("sub_early_stop", 4'd0, 1'b1, 4'd3);
`else
    exp_q = '{4'd6, 4'd4, 4'd2, 4'd0, 4'd14, 4'd12, 4'd10, 4'd8};
    send_cmd(3'd4, 4'd6, 4'd2, 3'd7);
    run_issue();
    check_done("sub_full_wrap", 4'd6, 1'b0, 4'd8);
`endif
    handshake();
    check_idle("sub_after_handshake");
  endtask

  task automatic test_shl();
    exp_q = '{4'd1, 4'd2, 4'd4, 4'd8};
    send_cmd(3'd3, 4'd1, 4'd0, 3'd3);
    run_issue();
    check_done("shl_overflow_zero", 4'd0, 1'b1, 4'd4);
    handshake();
    check_idle("shl_after_handshake");
  endtask

  task automatic test_stall();
    exp_q = '{4'd9};
    send_cmd(3'd5, 4'd9, 4'd9, 3'd0);
    run_issue();
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 4'd1; cmd_b = 4'd1; cmd_count = 3'd0;
    for (int i = 0; i < 5; i++) begin
      check_done("stall_hold", 4'd0, 1'b1, 4'd1);
      step();
    end
    cmd_valid = 1'b0;
    check_done("stall_before_release", 4'd0, 1'b1, 4'd1);
    handshake();
    check_idle("stall_after_handshake");
    step();
    check_idle("stall_ignored_cmd_not_queued");
  endtask

  task automatic test_reset_abort();
    int seen;
    exp_q = '{4'd0};
    send_cmd(3'd2, 4'd0, 4'd1, 3'd5);
    run_issue();
    #2 rst = 1'b1;
    #1;
    total++;
    if (dbg_state !== ST_IDLE || alu_src_a !== 4'd0 || alu_src_b !== 4'd0 ||
        alu_operation !== 3'd0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort_async: st=%0d a=%0d b=%0d op=%0d rv=%0b required all 0",
               dbg_state, alu_src_a, alu_src_b, alu_operation, rsp_valid);
    end
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_abort_no_rsp: rsp_valid cycles=%0d required 0", seen);
    end
    check_idle("reset_abort_idle");
    exp_q = '{4'd1};
    send_cmd(3'd2, 4'd1, 4'd1, 3'd0);
    run_issue();
    check_done("after_abort_cmd", 4'd2, 1'b0, 4'd1);
    handshake();
    check_idle("after_abort_idle");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shl();
    test_stall();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
